tu_align_sequencer: RTL and testbench

- Sequences trigger-link bitslip alignment across N_CH trigger-unit bitslip generators, one channel at a time.
- Each alignment engine issues parallel bitslips to its ISERDES. Engines must not all run at once, and a single engine gives no failure indication.
- This block raises each channel's enable, watches for a success edge or a timeout, retries, and records per-channel lock/fail status for the AXI register bank.

---
 rtl/tu_align_pkg.sv | 28 ++
 rtl/tu_align_timer.sv | 51 +++++
 rtl/tu_align_sequencer.sv | 179 +++++++++++++++++
 tb/tb_tu_align_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tu_align_pkg.sv
// Shared definitions for the trigger-link alignment sequencer: one-hot FSM
// encoding, default timing parameters and a constant clog2 helper.
package tu_align_pkg;

   typedef enum logic [5:0] {
      ST_IDLE     = 6'b000001,
      ST_SELECT   = 6'b000010,
      ST_ARM      = 6'b000100,
      ST_WAIT_RES = 6'b001000,
      ST_GAP      = 6'b010000,
      ST_DONE     = 6'b100000
   } state_e;

   localparam int DEF_N_CH      = 8;
   // Engine worst case is 2501 slips at ~6 cycles each, so 20000 leaves margin.
   localparam int DEF_TIMEOUT   = 20000;
   localparam int DEF_MAX_RETRY = 2;
   // Long enough for an engine to fall back to IDLE after its enable drops.
   localparam int DEF_GAP       = 16;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res = res + 1;
      return res;
   endfunction

endpackage

// File: rtl/tu_align_timer.sv
// Attempt timer and inter-attempt gap counter. Both clear on clr, count only
// while their run input is high, and hold at their last value instead of wrapping.
module tu_align_timer
   import tu_align_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int GAP     = DEF_GAP
) (
   input  logic S_AXI_ACLK,
   input  logic S_AXI_ARESETN,
   input  logic clr,
   input  logic run_attempt,
   input  logic run_gap,
   output logic timeout_hit,
   output logic gap_done
);

   localparam int TW = clog2(TIMEOUT + 1);
   localparam int GW = clog2(GAP + 1);
   localparam logic [TW-1:0] ATT_LAST = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

   logic [TW-1:0] att_cnt;
   logic [GW-1:0] gap_cnt;

   // Attempt timer: counts WAIT_RES cycles, saturating at TIMEOUT-1.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         att_cnt <= '0;
      end else if (clr) begin
         att_cnt <= '0;
      end else if (run_attempt && (att_cnt != ATT_LAST)) begin
         att_cnt <= att_cnt + 1'b1;
      end
   end

   // Gap counter: counts enable-low cycles in GAP, saturating at GAP-1.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         gap_cnt <= '0;
      end else if (clr) begin
         gap_cnt <= '0;
      end else if (run_gap && (gap_cnt != GAP_LAST)) begin
         gap_cnt <= gap_cnt + 1'b1;
      end
   end

   assign timeout_hit = run_attempt && (att_cnt == ATT_LAST);
   assign gap_done    = run_gap && (gap_cnt == GAP_LAST);

endmodule

// File: rtl/tu_align_sequencer.sv
// Runs bitslip alignment on one trigger channel at a time: pulses the engine
// enable, waits for a success edge or a timeout, retries, and keeps per-channel
// locked/failed status for the register bank.
module tu_align_sequencer
   import tu_align_pkg::*;
#(
   parameter int N_CH      = DEF_N_CH,
   parameter int CH_W      = clog2(N_CH),
   parameter int TIMEOUT   = DEF_TIMEOUT,
   parameter int MAX_RETRY = DEF_MAX_RETRY,
   parameter int GAP       = DEF_GAP
) (
   input  logic            S_AXI_ACLK,
   input  logic            S_AXI_ARESETN,
   input  logic            start,
   input  logic            abort,
   input  logic [N_CH-1:0] ch_mask,
   input  logic [N_CH-1:0] tu_success_in,
   output logic [N_CH-1:0] bitslip_ena_out,
   output logic            busy,
   output logic            done,
   output logic [N_CH-1:0] locked,
   output logic [N_CH-1:0] failed,
   output logic [CH_W-1:0] cur_ch,
   output logic [1:0]      retry_cnt
);

   localparam int SW = CH_W + 1;

   state_e          state_q, state_d;
   logic [N_CH-1:0] mask_q;
   logic [N_CH-1:0] succ_q;
   logic [N_CH-1:0] ena_d;
   logic [SW-1:0]   scan_q;
   logic            retry_pend_q;
   logic            found;
   logic [CH_W-1:0] sel_ch;
   logic            succ_edge;
   logic            retry_left;
   logic            timeout_hit;
   logic            gap_done;
   logic            timer_clr;
   logic            busy_d;
   logic            done_d;

   assign succ_edge  = tu_success_in[cur_ch] & ~succ_q[cur_ch];
   assign retry_left = (int'(retry_cnt) < MAX_RETRY);
   // Any state change restarts both counters, so each WAIT_RES/GAP visit starts at 0.
   assign timer_clr  = (state_d != state_q);

   tu_align_timer #(
      .TIMEOUT (TIMEOUT),
      .GAP     (GAP)
   ) u_timer (
      .S_AXI_ACLK    (S_AXI_ACLK),
      .S_AXI_ARESETN (S_AXI_ARESETN),
      .clr           (timer_clr),
      .run_attempt   (state_q == ST_WAIT_RES),
      .run_gap       (state_q == ST_GAP),
      .timeout_hit   (timeout_hit),
      .gap_done      (gap_done)
   );

   // Priority scan: lowest masked channel at or above the scan index.
   always_comb begin
      found  = 1'b0;
      sel_ch = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask_q[i] && (SW'(i) >= scan_q)) begin
            found  = 1'b1;
            sel_ch = CH_W'(i);
         end
      end
   end

   // State register.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) state_q <= ST_IDLE;
      else                state_q <= state_d;
   end

   // Next-state logic; abort overrides everything outside IDLE.
   always_comb begin
      state_d = state_q;
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:     if (start) state_d = ST_SELECT;
            ST_SELECT:   state_d = found ? ST_ARM : ST_DONE;
            ST_ARM:      state_d = ST_WAIT_RES;
            ST_WAIT_RES: if (succ_edge || timeout_hit) state_d = ST_GAP;
            ST_GAP:      if (gap_done) state_d = retry_pend_q ? ST_ARM : ST_SELECT;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   // Output decode from the next state so the registered outputs line up with it.
   always_comb begin
      ena_d = '0;
      if (state_d == ST_WAIT_RES) ena_d[cur_ch] = 1'b1;
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // Output registers; reset drops every enable immediately.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         bitslip_ena_out <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         bitslip_ena_out <= ena_d;
         busy            <= busy_d;
         done            <= done_d;
      end
   end

   // Registered copy of tu_success_in for rising-edge detection.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) succ_q <= '0;
      else                succ_q <= tu_success_in;
   end

   // Sequence bookkeeping: mask latch, scan index, channel, retries and status.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         mask_q       <= '0;
         scan_q       <= '0;
         retry_pend_q <= 1'b0;
         locked       <= '0;
         failed       <= '0;
         cur_ch       <= '0;
         retry_cnt    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mask_q       <= ch_mask;
                  locked       <= locked & ~ch_mask;
                  failed       <= failed & ~ch_mask;
                  scan_q       <= '0;
                  retry_pend_q <= 1'b0;
               end
            end
            ST_SELECT: begin
               if (!abort && found) begin
                  cur_ch       <= sel_ch;
                  retry_cnt    <= '0;
                  retry_pend_q <= 1'b0;
               end
            end
            ST_WAIT_RES: begin
               if (!abort) begin
                  // Success takes priority over a timeout in the same cycle.
                  if (succ_edge) begin
                     locked[cur_ch] <= 1'b1;
                     scan_q         <= {1'b0, cur_ch} + SW'(1);
                     retry_pend_q   <= 1'b0;
                  end else if (timeout_hit) begin
                     if (retry_left) begin
                        retry_cnt    <= retry_cnt + 2'd1;
                        retry_pend_q <= 1'b1;
                     end else begin
                        failed[cur_ch] <= 1'b1;
                        scan_q         <= {1'b0, cur_ch} + SW'(1);
                        retry_pend_q   <= 1'b0;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tu_align_sequencer.sv
// Directed bench for tu_align_sequencer. Two instances share the stimulus: a
// long-timeout one for the ordering/stale-success runs and a TIMEOUT=64 one for
// retry, tie, busy-start, abort and reset runs. A monitor pops expected enable
// pulses and done-time status from queues filled by the directed steps.
module tb_tu_align_sequencer;

   typedef struct {
      logic [7:0] ena;
      int         len;
      int         gap;
   } pulse_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [7:0] mask;
   logic [7:0] succ;
   logic       sel_small;
   logic [7:0] mask_b, mask_s;

   logic [7:0] ena_b, locked_b, failed_b, ena_s, locked_s, failed_s;
   logic       busy_b, done_b, busy_s, done_s;
   logic [2:0] cur_b, cur_s;
   logic [1:0] retry_b, retry_s;

   logic [7:0] ena, locked, failed;
   logic       busy, done;
   logic [2:0] cur_ch;
   logic [1:0] retry;

   int n_tests = 0;
   int n_fail  = 0;
   int n;

   pulse_t     pq[$];
   logic [15:0] dq[$];
   logic [7:0] prev_ena = '0;
   int         hi_cnt = 0;
   int         lo_cnt = 0;
   int         cur_len = -1;

   assign mask_b = sel_small ? 8'h00 : mask;
   assign mask_s = sel_small ? mask : 8'h00;

   assign ena    = sel_small ? ena_s    : ena_b;
   assign locked = sel_small ? locked_s : locked_b;
   assign failed = sel_small ? failed_s : failed_b;
   assign busy   = sel_small ? busy_s   : busy_b;
   assign done   = sel_small ? done_s   : done_b;
   assign cur_ch = sel_small ? cur_s    : cur_b;
   assign retry  = sel_small ? retry_s  : retry_b;

   tu_align_sequencer #(
      .N_CH(8), .CH_W(3), .TIMEOUT(20000), .MAX_RETRY(2), .GAP(16)
   ) u_big (
      .S_AXI_ACLK      (clk),
      .S_AXI_ARESETN   (rst_n),
      .start           (start),
      .abort           (abort),
      .ch_mask         (mask_b),
      .tu_success_in   (succ),
      .bitslip_ena_out (ena_b),
      .busy            (busy_b),
      .done            (done_b),
      .locked          (locked_b),
      .failed          (failed_b),
      .cur_ch          (cur_b),
      .retry_cnt       (retry_b)
   );

   tu_align_sequencer #(
      .N_CH(8), .CH_W(3), .TIMEOUT(64), .MAX_RETRY(2), .GAP(16)
   ) u_small (
      .S_AXI_ACLK      (clk),
      .S_AXI_ARESETN   (rst_n),
      .start           (start),
      .abort           (abort),
      .ch_mask         (mask_s),
      .tu_success_in   (succ),
      .bitslip_ena_out (ena_s),
      .busy            (busy_s),
      .done            (done_s),
      .locked          (locked_s),
      .failed          (failed_s),
      .cur_ch          (cur_s),
      .retry_cnt       (retry_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void push_p(input logic [7:0] e, input int len, input int gap);
      pulse_t p;
      p.ena = e;
      p.len = len;
      p.gap = gap;
      pq.push_back(p);
   endfunction

   task automatic pulse_start(input logic [7:0] m);
      @(negedge clk);
      mask  = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_ena(input int ch, input int limit, output int cnt);
      bit hit;
      hit = 1'b0;
      cnt = 0;
      for (int i = 1; i <= limit && !hit; i++) begin
         @(negedge clk);
         if (ena[ch]) begin
            hit = 1'b1;
            cnt = i;
         end
      end
      if (!hit) chk("wait_ena", {31'b0, ena[ch]}, 32'd1);
   endtask

   task automatic wait_done(input int limit);
      bit hit;
      hit = 1'b0;
      for (int i = 1; i <= limit && !hit; i++) begin
         @(negedge clk);
         if (done) hit = 1'b1;
      end
      if (!hit) chk("wait_done", {31'b0, done}, 32'd1);
   endtask

   // Monitor: scoreboard of enable pulses (channel, length, preceding low time) and done status.
   always @(negedge clk) begin
      if ((ena != 8'h00) && (prev_ena == 8'h00)) begin
         chk("onehot", $countones(ena), 32'd1);
         if (pq.size() == 0) begin
            chk("unexpected_pulse", {24'b0, ena}, 32'd0);
            cur_len = -1;
         end else begin
            pulse_t p;
            p = pq.pop_front();
            chk("pulse_ch", {24'b0, ena}, {24'b0, p.ena});
            if (p.gap >= 0) chk("pulse_gap", lo_cnt, p.gap);
            cur_len = p.len;
         end
         hi_cnt = 1;
      end else if (ena != 8'h00) begin
         hi_cnt++;
      end
      if ((ena == 8'h00) && (prev_ena != 8'h00)) begin
         if (cur_len >= 0) chk("pulse_len", hi_cnt, cur_len);
         lo_cnt = 1;
      end else if (ena == 8'h00) begin
         lo_cnt++;
      end
      if (done === 1'b1) begin
         if (dq.size() == 0) chk("unexpected_done", {31'b0, done}, 32'd0);
         else                chk("done_status", {16'b0, locked, failed}, {16'b0, dq.pop_front()});
      end
      prev_ena = ena;
   end

   initial begin
      rst_n = 1'b1; start = 1'b0; abort = 1'b0; mask = 8'h00; succ = 8'h00; sel_small = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_big",   {1'b0, ena_b, busy_b, done_b, locked_b, failed_b, cur_b, retry_b}, 32'd0);
      chk("reset_small", {1'b0, ena_s, busy_s, done_s, locked_s, failed_s, cur_s, retry_s}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Mask 05: ch0 locks after 100 cycles, ch2 after 50; 16 GAP + SELECT + ARM low between.
      push_p(8'h01, 101, -1);
      push_p(8'h04, 51, 18);
      dq.push_back({8'h05, 8'h00});
      pulse_start(8'h05);
      chk("t1_busy_k1", {31'b0, busy}, 32'd1);
      wait_ena(0, 10, n);
      chk("t1_ena_latency", n, 32'd2);
      repeat (100) @(negedge clk);
      succ[0] = 1'b1;
      wait_ena(2, 200, n);
      repeat (50) @(negedge clk);
      succ[2] = 1'b1;
      wait_done(200);
      @(negedge clk);
      chk("t1_busy_end", {31'b0, busy}, 32'd0);

      // Empty mask: done at k+2, status untouched, no enable.
      dq.push_back({8'h05, 8'h00});
      pulse_start(8'h00);
      chk("t4_busy_k1", {31'b0, busy}, 32'd1);
      chk("t4_done_k1", {31'b0, done}, 32'd0);
      @(negedge clk);
      chk("t4_done_k2", {31'b0, done}, 32'd1);
      @(negedge clk);
      chk("t4_done_k3", {31'b0, done}, 32'd0);
      chk("t4_busy_k3", {31'b0, busy}, 32'd0);

      // Stale success: ch0 success already high; only a fresh rising edge locks.
      succ = 8'h01;
      repeat (3) @(negedge clk);
      push_p(8'h01, 32, -1);
      dq.push_back({8'h05, 8'h00});
      pulse_start(8'h01);
      wait_ena(0, 10, n);
      repeat (30) @(negedge clk);
      chk("t4_stale_locked", {24'b0, locked}, 32'h04);
      chk("t4_stale_ena", {24'b0, ena}, 32'h01);
      succ[0] = 1'b0;
      @(negedge clk);
      succ[0] = 1'b1;
      wait_done(100);
      succ = 8'h00;
      @(negedge clk);
      sel_small = 1'b1;
      repeat (2) @(negedge clk);

      // Failure after retries: three 64-cycle pulses, then failed[1].
      push_p(8'h02, 64, -1);
      push_p(8'h02, 64, 17);
      push_p(8'h02, 64, 17);
      dq.push_back({8'h00, 8'h02});
      pulse_start(8'h02);
      wait_ena(1, 10, n);
      chk("t2_retry0", {30'b0, retry}, 32'd0);
      repeat (64) @(negedge clk);
      wait_ena(1, 40, n);
      chk("t2_retry1", {30'b0, retry}, 32'd1);
      repeat (64) @(negedge clk);
      wait_ena(1, 40, n);
      chk("t2_retry2", {30'b0, retry}, 32'd2);
      wait_done(120);
      chk("t2_retry_end", {30'b0, retry}, 32'd2);

      // Success on retry: first attempt times out, second sees an edge at cycle 10.
      push_p(8'h02, 64, -1);
      push_p(8'h02, 11, 17);
      dq.push_back({8'h02, 8'h00});
      pulse_start(8'h02);
      wait_ena(1, 10, n);
      repeat (64) @(negedge clk);
      wait_ena(1, 40, n);
      repeat (10) @(negedge clk);
      succ[1] = 1'b1;
      wait_done(100);
      chk("t3_retry_at_lock", {30'b0, retry}, 32'd1);
      succ = 8'h00;

      // Tie: edge in the same cycle the timer reaches TIMEOUT-1; success wins.
      push_p(8'h01, 64, -1);
      dq.push_back({8'h03, 8'h00});
      pulse_start(8'h01);
      wait_ena(0, 10, n);
      repeat (63) @(negedge clk);
      succ[0] = 1'b1;
      wait_done(100);
      chk("t6_no_retry", {30'b0, retry}, 32'd0);
      succ = 8'h00;

      // start while busy is ignored.
      push_p(8'h04, 5, -1);
      dq.push_back({8'h07, 8'h00});
      pulse_start(8'h04);
      wait_ena(2, 10, n);
      mask  = 8'hFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mask  = 8'h04;
      chk("t5_busy_start_locked", {24'b0, locked}, 32'h03);
      chk("t5_busy_start_ch", {29'b0, cur_ch}, 32'd2);
      repeat (3) @(negedge clk);
      succ[2] = 1'b1;
      wait_done(100);
      succ = 8'h00;

      // Abort during WAIT_RES: enable and busy drop next cycle, no done.
      push_p(8'h08, 11, -1);
      pulse_start(8'h08);
      wait_ena(3, 10, n);
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t5_abort_ena", {24'b0, ena}, 32'd0);
      chk("t5_abort_busy", {31'b0, busy}, 32'd0);
      chk("t5_abort_done", {31'b0, done}, 32'd0);
      repeat (20) @(negedge clk);
      chk("t5_abort_locked", {24'b0, locked}, 32'h07);
      chk("t5_abort_failed", {24'b0, failed}, 32'h00);

      // Reset mid-run: every output clears without waiting for a clock edge.
      push_p(8'h01, 6, -1);
      pulse_start(8'h01);
      wait_ena(0, 10, n);
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_rst_small", {1'b0, ena_s, busy_s, done_s, locked_s, failed_s, cur_s, retry_s}, 32'd0);
      chk("t5_rst_big",   {1'b0, ena_b, busy_b, done_b, locked_b, failed_b, cur_b, retry_b}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_post_rst_busy", {31'b0, busy}, 32'd0);

      chk("pulse_queue_empty", pq.size(), 32'd0);
      chk("done_queue_empty", dq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
